period_meter: RTL and testbench

- Receive-side counterpart to the peripheral clock dividers.
- Takes a slow, possibly asynchronous square wave (for example a divided clock or an external tick) and measures it in `clkin` cycles:
  - full period, rising edge to rising edge;
  - high time, rising edge to falling edge.
- Used by the CPU peripheral bus for self-test of the dividers and for frequency readback.
- Reports `locked` once two consecutive periods are identical.

---
 rtl/period_meter.sv | 136 +++++++++++++
 tb/tb_period_meter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures period and high time of a slow, possibly asynchronous square wave in clkin cycles.
// Publishes on every synchronized rising edge after the first; flags lock and sticky overflow.
module period_meter #(
   parameter int CNT_W = 16
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             clear,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             locked,
   output logic             overflow
);

   typedef enum logic {
      IDLE,
      MEASURE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] hshadow_q, hshadow_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             ovf_q, ovf_d;
   logic             rise, fall;

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      hshadow_d = hshadow_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      ovf_d     = ovf_q;

      // clear beats both a coincident rise and a timeout
      if (clear) begin
         state_d   = IDLE;
         cnt_d     = '0;
         hcnt_d    = '0;
         hshadow_d = '0;
         period_d  = '0;
         high_d    = '0;
         locked_d  = 1'b0;
         ovf_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  cnt_d     = CNT_ONE;
                  hcnt_d    = CNT_ONE;
                  hshadow_d = '0;
                  state_d   = MEASURE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_d  = cnt_q;
                  high_d    = hshadow_q;
                  valid_d   = 1'b1;
                  locked_d  = (cnt_q == period_q);
                  cnt_d     = CNT_ONE;
                  hcnt_d    = CNT_ONE;
                  hshadow_d = '0;
               end else if (cnt_q == CNT_MAX) begin
                  ovf_d    = 1'b1;
                  locked_d = 1'b0;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (s2_q) begin
                     hcnt_d = hcnt_q + CNT_ONE;
                  end
                  // at the fall cycle s2 is already low, so hcnt holds the full high count
                  if (fall) begin
                     hshadow_d = hcnt_q;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         hshadow_q <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_q      <= sig_in;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         hshadow_q <= hshadow_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         ovf_q     <= ovf_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_q;
   assign valid     = valid_q;
   assign locked    = locked_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: timestamp-based reference model feeding a publish scoreboard,
// with directed square waves plus randomized periods and clear pulses.
module tb_period_meter;

   localparam int CW   = 8;
   localparam int MAXC = (1 << CW) - 1;

   logic          clkin;
   logic          reset;
   logic          sig_in;
   logic          clear;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          valid;
   logic          locked;
   logic          overflow;

   int checks = 0;
   int errors = 0;
   int pubs   = 0;
   int ecnt   = 0;

   typedef struct {
      int            e;
      logic [CW-1:0] per;
      logic [CW-1:0] hi;
      logic          lk;
      logic          ov;
   } pub_t;

   pub_t pub_q[$];

   period_meter #(.CNT_W(CW)) dut (
      .clkin     (clkin),
      .reset     (reset),
      .sig_in    (sig_in),
      .clear     (clear),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .locked    (locked),
      .overflow  (overflow)
   );

   initial begin
      clkin = 1'b0;
      forever #5 clkin = ~clkin;
   end

   // Reference model works on timestamps: an input level sampled at edge k is seen as an edge at k+2
   logic [CW-1:0] m_period, m_high;
   logic          m_locked, m_ovf, m_meas;
   logic          h1, h2, h3;
   int            last_e, fall_e;
   bit            fall_seen;

   always @(posedge clkin) begin
      logic          r, f;
      logic [CW-1:0] per, hi;
      pub_t          p;
      ecnt++;
      if (!reset) begin
         m_period  = '0;
         m_high    = '0;
         m_locked  = 1'b0;
         m_ovf     = 1'b0;
         m_meas    = 1'b0;
         fall_seen = 1'b0;
         h1 = 1'b0;
         h2 = 1'b0;
         h3 = 1'b0;
      end else begin
         r = h2 & ~h3;
         f = ~h2 & h3;
         if (clear) begin
            m_period  = '0;
            m_high    = '0;
            m_locked  = 1'b0;
            m_ovf     = 1'b0;
            m_meas    = 1'b0;
            fall_seen = 1'b0;
         end else if (r) begin
            if (m_meas) begin
               per      = CW'(ecnt - last_e);
               hi       = fall_seen ? CW'(fall_e - last_e) : '0;
               p.e      = ecnt;
               p.per    = per;
               p.hi     = hi;
               p.lk     = (per == m_period);
               p.ov     = m_ovf;
               m_period = per;
               m_high   = hi;
               m_locked = p.lk;
               pub_q.push_back(p);
               pubs++;
            end
            last_e    = ecnt;
            fall_seen = 1'b0;
            m_meas    = 1'b1;
         end else if (m_meas && (ecnt - last_e) == MAXC) begin
            m_ovf    = 1'b1;
            m_locked = 1'b0;
            m_meas   = 1'b0;
         end else if (f && m_meas) begin
            fall_seen = 1'b1;
            fall_e    = ecnt;
         end
         h3 = h2;
         h2 = h1;
         h1 = sig_in;
      end
   end

   // Monitor: pops the scoreboard on every valid pulse and tracks the held outputs each cycle
   always @(posedge clkin) begin
      pub_t p;
      #2;
      if (valid) begin
         checks++;
         if (pub_q.size() == 0 || pub_q[0].e != ecnt) begin
            errors++;
            $display("[TB] FAIL unexpected_valid at edge %0d: got valid=1, exp valid=0", ecnt);
            if (pub_q.size() != 0 && pub_q[0].e < ecnt) void'(pub_q.pop_front());
         end else begin
            p = pub_q.pop_front();
            if (period !== p.per || high_time !== p.hi || locked !== p.lk || overflow !== p.ov) begin
               errors++;
               $display("[TB] FAIL publish at edge %0d: got per=%0d hi=%0d lk=%0b ov=%0b, exp per=%0d hi=%0d lk=%0b ov=%0b",
                        ecnt, period, high_time, locked, overflow, p.per, p.hi, p.lk, p.ov);
            end
         end
      end else if (pub_q.size() != 0 && pub_q[0].e <= ecnt) begin
         checks++;
         errors++;
         $display("[TB] FAIL missed_valid at edge %0d: got valid=0, exp valid=1 per=%0d", ecnt, pub_q[0].per);
         void'(pub_q.pop_front());
      end
      checks++;
      if (period !== m_period || high_time !== m_high || locked !== m_locked || overflow !== m_ovf) begin
         errors++;
         $display("[TB] FAIL state at edge %0d: got per=%0d hi=%0d lk=%0b ov=%0b, exp per=%0d hi=%0d lk=%0b ov=%0b",
                  ecnt, period, high_time, locked, overflow, m_period, m_high, m_locked, m_ovf);
      end
   end

   task automatic applyStimulus(input logic lvl, input int n, input int clr_pct);
      repeat (n) begin
         @(negedge clkin);
         sig_in = lvl;
         clear  = (clr_pct > 0) && ($urandom_range(0, 99) < clr_pct);
      end
   endtask

   task automatic squareWave(input int hi, input int lo, input int n);
      repeat (n) begin
         applyStimulus(1'b1, hi, 0);
         applyStimulus(1'b0, lo, 0);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, exp %0d", name, got, exp);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, exp finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r;
      reset  = 1'b0;
      sig_in = 1'b0;
      clear  = 1'b0;
      repeat (3) @(negedge clkin);
      checkOutput("reset_period", 32'(period), 0);
      checkOutput("reset_valid", 32'(valid), 0);
      checkOutput("reset_ovf", 32'(overflow), 0);

      // divide-by-16 started together with reset release
      @(negedge clkin);
      reset  = 1'b1;
      sig_in = 1'b1;
      applyStimulus(1'b1, 7, 0);
      applyStimulus(1'b0, 8, 0);
      squareWave(8, 8, 7);
      checkOutput("div16_period", 32'(period), 16);
      checkOutput("div16_high", 32'(high_time), 8);
      checkOutput("div16_locked", 32'(locked), 1);

      squareWave(12, 12, 5);
      checkOutput("div24_period", 32'(period), 24);
      checkOutput("div24_locked", 32'(locked), 1);

      // clear lands on the edge where the synchronized rise is seen
      @(negedge clkin);
      sig_in = 1'b1;
      @(negedge clkin);
      @(negedge clkin);
      clear = 1'b1;
      @(negedge clkin);
      clear = 1'b0;
      checkOutput("clear_period", 32'(period), 0);
      checkOutput("clear_locked", 32'(locked), 0);
      checkOutput("clear_valid", 32'(valid), 0);
      applyStimulus(1'b1, 8, 0);
      applyStimulus(1'b0, 12, 0);
      squareWave(12, 12, 3);
      checkOutput("after_clear_period", 32'(period), 24);

      // asynchronous 37/63 wave with random sub-cycle phase
      @(negedge clkin);
      r = $urandom_range(1, 8);
      if (r >= 5) r++;
      #(r);
      repeat (6) begin
         sig_in = 1'b1;
         #370;
         sig_in = 1'b0;
         #630;
      end
      @(negedge clkin);
      checkOutput("async_period", 32'(period), 100);
      checkOutput("async_high", 32'(high_time), 37);
      checkOutput("async_locked", 32'(locked), 1);
      checkOutput("async_ovf", 32'(overflow), 0);

      // timeout after a lone rise, then recovery with overflow still sticky
      applyStimulus(1'b1, 10, 0);
      applyStimulus(1'b0, 300, 0);
      checkOutput("timeout_ovf", 32'(overflow), 1);
      checkOutput("timeout_locked", 32'(locked), 0);
      squareWave(10, 10, 3);
      checkOutput("recover_period", 32'(period), 20);
      checkOutput("recover_ovf", 32'(overflow), 1);

      // reset pulse in the middle of a high phase
      applyStimulus(1'b1, 5, 0);
      @(negedge clkin);
      reset = 1'b0;
      applyStimulus(1'b1, 3, 0);
      checkOutput("midreset_period", 32'(period), 0);
      checkOutput("midreset_ovf", 32'(overflow), 0);
      @(negedge clkin);
      reset = 1'b1;
      applyStimulus(1'b0, 8, 0);
      squareWave(8, 8, 4);
      checkOutput("midreset_resume_period", 32'(period), 16);

      // random periods with occasional clear pulses
      repeat (25) begin
         applyStimulus(1'b1, $urandom_range(2, 30), 3);
         applyStimulus(1'b0, $urandom_range(2, 30), 3);
      end
      applyStimulus(1'b0, 20, 0);

      checkOutput("scoreboard_drained", 32'(pub_q.size()), 0);
      checks++;
      if (pubs < 40) begin
         errors++;
         $display("[TB] FAIL publish_count: got %0d, exp at least 40", pubs);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
